// File: rtl/ldm_stm_pkg.sv
// Shared definitions for the block-transfer (LDM/STM) sequencer.
//   state_e : sequencer state encoding (IDLE, XFER, FIN)
//   am_e    : addressing mode, encoded as {P, U}
//   WORD_BYTES : byte stride between consecutive transfers
package ldm_stm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // {pre-index, up}
  typedef enum logic [1:0] {
    AM_DA = 2'b00,
    AM_IA = 2'b01,
    AM_DB = 2'b10,
    AM_IB = 2'b11
  } am_e;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/ldm_stm_seq_lsb_find.sv
// Lowest-set-bit finder for the remaining register pattern.
//   pat      in  : remaining register pattern
//   idx      out : index of the lowest set bit (0 when pat is empty)
//   next_pat out : pat with its lowest set bit cleared
//   empty    out : pat has no bits set
module lsb_find #(
  parameter int RLIST_W = 16,
  parameter int RADDR_W = 4
) (
  input  logic [RLIST_W-1:0] pat,
  output logic [RADDR_W-1:0] idx,
  output logic [RLIST_W-1:0] next_pat,
  output logic               empty
);

  // Scan from the top down so the last hit wins: the lowest set bit.
  always_comb begin
    idx = '0;
    for (int i = RLIST_W - 1; i >= 0; i--) begin
      if (pat[i]) idx = RADDR_W'(i);
    end
  end

  assign next_pat = pat & (pat - RLIST_W'(1));
  assign empty    = (pat == '0);

endmodule

// File: rtl/ldm_stm_seq.sv
// Load/store-multiple sequencer. Latches a register list, base and mode bits
// on START, then issues one memory request per listed register in ascending
// register order at ascending word addresses, finishing with a one-cycle
// DONE / optional base-writeback strobe.
//   CLK, RST          : clock, async active-high reset
//   START, RLIST, BASE, IR_P/U/L/W : launch request and operands (IDLE only)
//   ABORT             : kill, returns to IDLE at the next edge
//   REQ, REQ_ADDR, REQ_REG, REQ_NRW, REQ_LAST, REQ_ACK : request handshake
//   BUSY, DONE, WB_EN, WB_VAL : status, completion and writeback
module ldm_stm_seq
  import ldm_stm_pkg::*;
#(
  parameter int RLIST_W = 16,
  parameter int RADDR_W = 4,
  parameter int AW      = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [RLIST_W-1:0] RLIST,
  input  logic [AW-1:0]      BASE,
  input  logic               IR_P,
  input  logic               IR_U,
  input  logic               IR_L,
  input  logic               IR_W,
  input  logic               ABORT,
  input  logic               REQ_ACK,
  output logic               BUSY,
  output logic               REQ,
  output logic [AW-1:0]      REQ_ADDR,
  output logic [RADDR_W-1:0] REQ_REG,
  output logic               REQ_NRW,
  output logic               REQ_LAST,
  output logic               WB_EN,
  output logic [AW-1:0]      WB_VAL,
  output logic               DONE
);

  state_e             state_q, state_d;
  logic [RLIST_W-1:0] pat_q, pat_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW-1:0]      wb_q, wb_d;
  logic               nrw_q, nrw_d;
  logic               w_q, w_d;

  logic [RADDR_W-1:0] cur_idx;
  logic [RLIST_W-1:0] next_pat;
  logic               pat_empty;
  logic               last;
  logic [AW-1:0]      pcnt;
  logic [AW-1:0]      nbytes;

  lsb_find #(.RLIST_W(RLIST_W), .RADDR_W(RADDR_W)) u_lsb (
    .pat      (pat_q),
    .idx      (cur_idx),
    .next_pat (next_pat),
    .empty    (pat_empty)
  );

  // Single remaining bit: clearing it leaves nothing.
  assign last = ~pat_empty & (next_pat == '0);

  always_comb begin
    pcnt = '0;
    for (int i = 0; i < RLIST_W; i++) pcnt = pcnt + AW'(RLIST[i]);
  end
  assign nbytes = pcnt * AW'(WORD_BYTES);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    addr_d  = addr_q;
    wb_d    = wb_q;
    nrw_d   = nrw_q;
    w_d     = w_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          pat_d = RLIST;
          nrw_d = ~IR_L;
          w_d   = IR_W;
          wb_d  = IR_U ? (BASE + nbytes) : (BASE - nbytes);
          // Decrementing modes still walk upward, so start at the low end.
          case (am_e'({IR_P, IR_U}))
            AM_IA:   addr_d = BASE;
            AM_IB:   addr_d = BASE + AW'(WORD_BYTES);
            AM_DA:   addr_d = BASE - nbytes + AW'(WORD_BYTES);
            AM_DB:   addr_d = BASE - nbytes;
            default: addr_d = BASE;
          endcase
          state_d = (RLIST == '0) ? ST_FIN : ST_XFER;
        end
      end
      ST_XFER: begin
        if (REQ_ACK && !ABORT) begin
          pat_d  = next_pat;
          addr_d = addr_q + AW'(WORD_BYTES);
          if (last) state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (ABORT) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      addr_q  <= '0;
      wb_q    <= '0;
      nrw_q   <= 1'b0;
      w_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      addr_q  <= addr_d;
      wb_q    <= wb_d;
      nrw_q   <= nrw_d;
      w_q     <= w_d;
    end
  end

  assign BUSY     = (state_q != ST_IDLE);
  assign REQ      = (state_q == ST_XFER);
  assign REQ_ADDR = addr_q;
  assign REQ_REG  = cur_idx;
  assign REQ_NRW  = nrw_q;
  assign REQ_LAST = (state_q == ST_XFER) & last;
  assign DONE     = (state_q == ST_FIN);
  assign WB_EN    = (state_q == ST_FIN) & w_q;
  assign WB_VAL   = wb_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
module tb_ldm_stm_seq;

  logic        CLK, RST;
  logic        START, IR_P, IR_U, IR_L, IR_W, ABORT, REQ_ACK;
  logic [15:0] RLIST;
  logic [31:0] BASE;
  logic        BUSY, REQ, REQ_NRW, REQ_LAST, WB_EN, DONE;
  logic [31:0] REQ_ADDR, WB_VAL;
  logic [3:0]  REQ_REG;

  logic        START8, ACK8, BUSY8, REQ8, NRW8, LAST8, WB_EN8, DONE8;
  logic [7:0]  RLIST8;
  logic [31:0] BASE8, ADDR8, WB_VAL8;
  logic [2:0]  REG8;

  int n_checks = 0;
  int n_fail   = 0;

  ldm_stm_seq #(.RLIST_W(16), .RADDR_W(4), .AW(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .RLIST(RLIST), .BASE(BASE),
    .IR_P(IR_P), .IR_U(IR_U), .IR_L(IR_L), .IR_W(IR_W), .ABORT(ABORT),
    .REQ_ACK(REQ_ACK), .BUSY(BUSY), .REQ(REQ), .REQ_ADDR(REQ_ADDR),
    .REQ_REG(REQ_REG), .REQ_NRW(REQ_NRW), .REQ_LAST(REQ_LAST),
    .WB_EN(WB_EN), .WB_VAL(WB_VAL), .DONE(DONE)
  );

  ldm_stm_seq #(.RLIST_W(8), .RADDR_W(3), .AW(32)) dut8 (
    .CLK(CLK), .RST(RST), .START(START8), .RLIST(RLIST8), .BASE(BASE8),
    .IR_P(1'b0), .IR_U(1'b1), .IR_L(1'b1), .IR_W(1'b0), .ABORT(1'b0),
    .REQ_ACK(ACK8), .BUSY(BUSY8), .REQ(REQ8), .REQ_ADDR(ADDR8),
    .REQ_REG(REG8), .REQ_NRW(NRW8), .REQ_LAST(LAST8),
    .WB_EN(WB_EN8), .WB_VAL(WB_VAL8), .DONE(DONE8)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: start address and writeback from the addressing rules.
  function automatic logic [31:0] m_start(input logic [15:0] rl, input logic [31:0] b,
                                          input bit p, input bit u);
    logic [31:0] nb;
    nb = 32'($countones(rl)) * 32'd4;
    if (u) return p ? b + 32'd4 : b;
    else   return p ? b - nb : b - nb + 32'd4;
  endfunction

  function automatic logic [31:0] m_wb(input logic [15:0] rl, input logic [31:0] b, input bit u);
    logic [31:0] nb;
    nb = 32'($countones(rl)) * 32'd4;
    return u ? b + nb : b - nb;
  endfunction

  // Launches one operation at a negedge and follows it to DONE.
  // ack_mode: 0 ack every cycle, 1 random ack + ignored START noise,
  //           2 stall 3 cycles on the second transfer.
  task automatic run_op(input logic [15:0] rl, input logic [31:0] b,
                        input bit p, input bit u, input bit l, input bit w,
                        input logic [31:0] exp_a0, input logic [31:0] exp_wb,
                        input int ack_mode);
    int regs[$];
    int idx = 0, cycles = 0, req_cycles = 0, stall = 0;
    bit done = 0, ack;
    for (int i = 0; i < 16; i++) if (rl[i]) regs.push_back(i);
    START = 1; RLIST = rl; BASE = b; IR_P = p; IR_U = u; IR_L = l; IR_W = w;
    @(negedge CLK);
    START = 0;
    while (!done && cycles < 200) begin
      ack = 0;
      if (REQ) begin
        req_cycles++;
        if (idx >= regs.size()) chk("req beyond list", 32'(idx), 32'(regs.size()));
        else begin
          chk("req_reg",  32'(REQ_REG), 32'(regs[idx]));
          chk("req_addr", REQ_ADDR, exp_a0 + 32'(idx) * 32'd4);
          chk("req_last", 32'(REQ_LAST), 32'(idx == regs.size() - 1));
          chk("req_nrw",  32'(REQ_NRW), 32'(!l));
        end
        case (ack_mode)
          0: ack = 1;
          1: ack = ($urandom_range(0, 2) != 0);
          default: begin
            if (idx == 1 && stall < 3) stall++;
            else ack = 1;
          end
        endcase
        if (ack) idx++;
      end
      if (DONE) begin
        chk("wb_en", 32'(WB_EN), 32'(w));
        chk("wb_val", WB_VAL, exp_wb);
        chk("all transfers done", 32'(idx), 32'(regs.size()));
        chk("fin latency", 32'(cycles), 32'(req_cycles));
        done = 1;
      end
      REQ_ACK = ack;
      if (ack_mode == 1) begin
        START = 1'($urandom_range(0, 1));
        RLIST = 16'($urandom);
        IR_W  = 1'($urandom_range(0, 1));
      end
      @(negedge CLK);
      cycles++;
    end
    START = 0; REQ_ACK = 0;
    chk("done seen", 32'(done), 32'd1);
    chk("idle after fin", 32'(BUSY), 32'd0);
  endtask

  typedef struct {
    logic [15:0] rl;
    logic [31:0] base;
    bit p, u, l, w;
    logic [31:0] a0, wb;
    int mode;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'h8005, 32'h1000, 0, 1, 1, 1, 32'h1000, 32'h100C, 0};
    vecs[1] = '{16'h00F0, 32'h2000, 1, 0, 0, 1, 32'h1FF0, 32'h1FF0, 0};
    vecs[2] = '{16'h8005, 32'h1000, 0, 1, 1, 0, 32'h1000, 32'h100C, 2};
    vecs[3] = '{16'h0000, 32'h3000, 0, 1, 1, 1, 32'h3000, 32'h3000, 0};
    vecs[4] = '{16'h0003, 32'h0100, 1, 1, 0, 0, 32'h0104, 32'h0108, 0};
    vecs[5] = '{16'h0007, 32'h0100, 0, 0, 1, 1, 32'h00F8, 32'h00F4, 2};
    vecs[6] = '{16'h0003, 32'h0000, 1, 0, 0, 1, 32'hFFFFFFF8, 32'hFFFFFFF8, 0};
    vecs[7] = '{16'hFFFF, 32'hFFFFFFF0, 0, 1, 1, 1, 32'hFFFFFFF0, 32'h00000030, 1};

    RST = 1; START = 0; RLIST = 0; BASE = 0; IR_P = 0; IR_U = 0; IR_L = 0; IR_W = 0;
    ABORT = 0; REQ_ACK = 0; START8 = 0; RLIST8 = 0; BASE8 = 0; ACK8 = 0;
    #1;
    chk("rst busy", 32'(BUSY), 0); chk("rst req", 32'(REQ), 0);
    chk("rst done", 32'(DONE), 0); chk("rst wb_en", 32'(WB_EN), 0);
    chk("rst addr", REQ_ADDR, 0);  chk("rst wb_val", WB_VAL, 0);
    @(negedge CLK);
    RST = 0;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].rl, vecs[i].base, vecs[i].p, vecs[i].u, vecs[i].l, vecs[i].w,
             vecs[i].a0, vecs[i].wb, vecs[i].mode);

    for (int t = 0; t < 30; t++) begin
      logic [15:0] rl; logic [31:0] b; bit p, u, l, w;
      rl = 16'($urandom);
      if ($urandom_range(0, 5) == 0) rl = 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) rl = 16'h0;
      b = $urandom;
      p = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
      run_op(rl, b, p, u, l, w, m_start(rl, b, p, u), m_wb(rl, b, u), 1);
    end

    // ABORT coinciding with the second ack.
    START = 1; RLIST = 16'h00F0; BASE = 32'h2000; IR_P = 1; IR_U = 0; IR_L = 0; IR_W = 1;
    @(negedge CLK);
    START = 0;
    chk("abort first reg", 32'(REQ_REG), 32'd4);
    REQ_ACK = 1;
    @(negedge CLK);
    chk("abort second reg", 32'(REQ_REG), 32'd5);
    ABORT = 1; REQ_ACK = 1;
    @(negedge CLK);
    ABORT = 0; REQ_ACK = 0;
    chk("abort busy", 32'(BUSY), 0); chk("abort req", 32'(REQ), 0);
    chk("abort done", 32'(DONE), 0); chk("abort wb_en", 32'(WB_EN), 0);
    run_op(16'h0102, 32'h500, 0, 1, 1, 1, 32'h500, 32'h508, 0);

    // Asynchronous reset mid-transfer.
    START = 1; RLIST = 16'h00F0; BASE = 32'h2000; IR_P = 1; IR_U = 0; IR_L = 0; IR_W = 1;
    @(negedge CLK);
    START = 0; REQ_ACK = 1;
    @(negedge CLK);
    REQ_ACK = 0;
    chk("pre-rst req", 32'(REQ), 1);
    #2 RST = 1;
    #1;
    chk("arst busy", 32'(BUSY), 0);     chk("arst req", 32'(REQ), 0);
    chk("arst last", 32'(REQ_LAST), 0); chk("arst nrw", 32'(REQ_NRW), 0);
    chk("arst addr", REQ_ADDR, 0);      chk("arst reg", 32'(REQ_REG), 0);
    chk("arst wb_val", WB_VAL, 0);      chk("arst done", 32'(DONE), 0);
    chk("arst wb_en", 32'(WB_EN), 0);
    @(negedge CLK);
    RST = 0;
    run_op(16'h8001, 32'h40, 0, 1, 0, 1, 32'h40, 32'h48, 0);

    // 8-register variant: registers 0 and 7.
    START8 = 1; RLIST8 = 8'h81; BASE8 = 32'h40;
    @(negedge CLK);
    START8 = 0; ACK8 = 1;
    chk("r8 req0", 32'(REQ8), 1); chk("r8 reg0", 32'(REG8), 0);
    chk("r8 addr0", ADDR8, 32'h40); chk("r8 last0", 32'(LAST8), 0);
    @(negedge CLK);
    chk("r8 req1", 32'(REQ8), 1); chk("r8 reg1", 32'(REG8), 7);
    chk("r8 addr1", ADDR8, 32'h44); chk("r8 last1", 32'(LAST8), 1);
    @(negedge CLK);
    ACK8 = 0;
    chk("r8 done", 32'(DONE8), 1); chk("r8 wb_en", 32'(WB_EN8), 0);
    chk("r8 wb_val", WB_VAL8, 32'h48); chk("r8 nrw", 32'(NRW8), 0);
    @(negedge CLK);
    chk("r8 idle", 32'(BUSY8), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ldm_stm_seq.md
LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 Parameter RLIST_W, default 16, register-list width (number of architectural registers); legal range 2..32.
REQ-002 Parameter RADDR_W, default 4, register-index width; SHALL equal ceil(log2(RLIST_W)).
REQ-003 Parameter AW, default 32, address width.
REQ-004 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 START  in  1  launch request; sampled in IDLE only.
REQ-007 RLIST  in  RLIST_W  register list; bit i set = register i transferred.
REQ-008 BASE  in  AW  base-register value.
REQ-009 IR_P, IR_U, IR_L, IR_W  in  1 each  pre-index, up, load, writeback; sampled with START.
REQ-010 ABORT  in  1  kill from interrupt or flush.
REQ-011 REQ_ACK  in  1  memory stage accepts the current request.
REQ-012 BUSY  out  1  high in every state except IDLE.
REQ-013 REQ  out  1  memory request valid.
REQ-014 REQ_ADDR  out  AW  word address of the current transfer.
REQ-015 REQ_REG  out  RADDR_W  register index of the current transfer.
REQ-016 REQ_NRW  out  1  1 = write (STM), 0 = read (LDM).
REQ-017 REQ_LAST  out  1  current request is the final transfer.
REQ-018 WB_EN  out  1  one-cycle base-writeback strobe.
REQ-019 WB_VAL  out  AW  base-writeback value.
REQ-020 DONE  out  1  one-cycle completion strobe.

Function
REQ-021 FSM states: IDLE, XFER, FIN.
REQ-022 IDLE with START=1 SHALL latch RLIST, BASE and the mode bits, compute n = popcount(RLIST), and move to XFER next cycle; if n=0, move to FIN instead.
REQ-023 Start address: IA (P=0, U=1) BASE; IB (P=1, U=1) BASE+4; DA (P=0, U=0) BASE-4n+4; DB (P=1, U=0) BASE-4n. Arithmetic is modulo 2^AW.
REQ-024 Writeback value SHALL be BASE+4n when U=1 and BASE-4n when U=0; it SHALL be latched at launch.
REQ-025 Transfers SHALL proceed in ascending register order at ascending addresses, 4 bytes apart, regardless of U.
REQ-026 XFER SHALL hold REQ=1, with REQ_REG equal to the lowest set bit of the remaining pattern.
REQ-027 REQ_ADDR, REQ_REG, REQ_NRW and REQ_LAST SHALL stay stable while REQ=1 and REQ_ACK=0.
REQ-028 On REQ_ACK=1 the lowest set bit SHALL be cleared and the address advanced by 4; the next request SHALL be presented the following cycle (one transfer per cycle maximum).
REQ-029 REQ_LAST=1 exactly when the remaining pattern has one set bit; an ack on LAST SHALL move the FSM to FIN.
REQ-030 FIN SHALL last one cycle: DONE=1, WB_EN=IR_W, WB_VAL valid; the FSM then returns to IDLE.
REQ-031 START is ignored outside IDLE. START in the cycle after FIN is accepted.
REQ-032 ABORT=1 in any state SHALL force IDLE at the next edge with no further REQ, WB_EN or DONE. If ABORT and REQ_ACK coincide, ABORT wins and the ack is discarded.
REQ-033 Register 15 (or RLIST_W-1) SHALL be treated like any other register; no special casing.

Reset
REQ-034 RST=1 SHALL immediately force IDLE and drive BUSY, REQ, REQ_LAST, WB_EN, DONE, REQ_NRW to 0 and REQ_ADDR, REQ_REG, WB_VAL to 0, including mid-transfer.
REQ-035 On RST deassertion the block SHALL be in IDLE and accept START on the first following edge.

Structure
REQ-036 Shared package ldm_stm_pkg SHALL hold the state encoding, the addressing-mode constants (IA, IB, DA, DB) and WORD_BYTES=4.
REQ-037 Sub-module lsb_find, parametrised by RLIST_W, SHALL implement the combinational lowest-set-bit index, the cleared-bit next pattern and the empty flag.
REQ-038 Popcount and start-address arithmetic SHALL be registered at launch; no combinational path from START to REQ.

Verification
REQ-039 IA load: RLIST=0x8005, BASE=0x1000, P=0, U=1, L=1, W=1, ack every cycle -> REQ_REG 0, 2, 15 at 0x1000, 0x1004, 0x1008; LAST on 15; FIN with WB_VAL=0x100C and DONE.
REQ-040 DB store: RLIST=0x00F0, BASE=0x2000, P=1, U=0, L=0 -> REQ_REG 4..7 at 0x1FF0..0x1FFC with REQ_NRW=1; WB_VAL=0x1FF0.
REQ-041 Backpressure: hold REQ_ACK=0 for 3 cycles on the second transfer -> REQ, REQ_ADDR and REQ_REG unchanged for those cycles; the total sequence is unaltered.
REQ-042 Empty list: RLIST=0, W=1, BASE=0x3000 -> no REQ ever; FIN the cycle after launch with WB_EN=1 and WB_VAL=0x3000.
REQ-043 ABORT with REQ_ACK in the cycle of the second ack -> IDLE next cycle, no DONE or WB_EN; a new START is accepted immediately afterwards.
REQ-044 RST pulse mid-XFER, and RLIST_W=8 with RLIST=0x81 -> all outputs 0 asynchronously; for the 8-bit case, REQ_REG 0 then 7 with RADDR_W=3.
